// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle datapath and its control FSM.
// The slave modport is the FSM side; the master modport drives opcode, zero and mem_ready.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [10:0]      OpCode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             Reg2Loc;
  logic             AluSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             Branch;
  logic             UncondBranch;
  logic [1:0]       Aluop;
  logic [2:0]       state;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output OpCode, zero, mem_ready,
    input  PCWrite, IRWrite, Reg2Loc, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, UncondBranch, Aluop, state, illegal, timeout, instr_count
  );

  modport slave (
    input  OpCode, zero, mem_ready,
    output PCWrite, IRWrite, Reg2Loc, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, UncondBranch, Aluop, state, illegal, timeout, instr_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle LEGv8 control FSM with memory-wait timeout and retired-instruction counter.
// Optional feature: define UNCOND_BRANCH_EN to make B legal; otherwise B decodes illegal.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_if.slave       bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int               WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) + 1 : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {OP_R, OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_ILL} op_class_e;

  function automatic op_class_e classify(input logic [10:0] op);
    op_class_e cls;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls = OP_R;
      11'b11111000010: cls = OP_LDUR;
      11'b11111000000: cls = OP_STUR;
      11'b10110100???: cls = OP_CBZ;
`ifdef UNCOND_BRANCH_EN
      11'b000101?????: cls = OP_B;
`endif
      default:         cls = OP_ILL;
    endcase
    return cls;
  endfunction

  logic [2:0]        r_state;
  logic [10:0]       r_opcode;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_count;

  logic [2:0]        w_next_state;
  op_class_e         w_class;
  op_class_e         w_dec_class;
  logic              w_wait_hit;
  logic              w_retire;
  logic              w_set_illegal;
  logic              w_set_timeout;
  logic              w_enter_wait;
  logic              w_in_wait;

  assign w_class     = classify(r_opcode);
  assign w_dec_class = classify(bus.OpCode);
  // The last permitted wait cycle: mem_ready still low here means the access has timed out.
  assign w_wait_hit  = (MEM_TIMEOUT != 0) && !bus.mem_ready && (r_wait == WAIT_LAST);
  assign w_in_wait   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_enter_wait = ((w_next_state == S_FETCH) || (w_next_state == S_MEM)) &&
                        (w_next_state != r_state);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_wait_hit) begin
          w_next_state  = S_HALT;
          w_set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_dec_class == OP_ILL) begin
          w_next_state  = S_HALT;
          w_set_illegal = 1'b1;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_class)
          OP_R:            w_next_state = S_WB;
          OP_LDUR, OP_STUR: w_next_state = S_MEM;
          OP_CBZ, OP_B: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
          end
          default:         w_next_state = S_HALT;
        endcase
      end
      S_MEM: begin
        if ((w_class != OP_LDUR) && (w_class != OP_STUR)) begin
          w_next_state = S_HALT;
        end else if (bus.mem_ready) begin
          w_next_state = (w_class == OP_LDUR) ? S_WB : S_FETCH;
          w_retire     = (w_class == OP_STUR);
        end else if (w_wait_hit) begin
          w_next_state  = S_HALT;
          w_set_timeout = 1'b1;
        end
      end
      S_WB: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      default: w_next_state = S_HALT;
    endcase
  end

  always_comb begin
    bus.PCWrite      = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.Reg2Loc      = 1'b0;
    bus.AluSrc       = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.Branch       = 1'b0;
    bus.UncondBranch = 1'b0;
    bus.Aluop        = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_EXEC: begin
        case (w_class)
          OP_R:    bus.Aluop = 2'b10;
          OP_LDUR: bus.AluSrc = 1'b1;
          OP_STUR: begin
            bus.AluSrc  = 1'b1;
            bus.Reg2Loc = 1'b1;
          end
          OP_CBZ: begin
            bus.Aluop   = 2'b01;
            bus.Reg2Loc = 1'b1;
            bus.Branch  = 1'b1;
            bus.PCWrite = bus.zero;
          end
          OP_B: begin
`ifdef UNCOND_BRANCH_EN
            bus.UncondBranch = 1'b1;
            bus.PCWrite      = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.MemRead  = (w_class == OP_LDUR);
        bus.MemWrite = (w_class == OP_STUR);
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (w_class == OP_LDUR);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_opcode <= bus.OpCode;
      if (w_enter_wait) begin
        r_wait <= '0;
      end else if (w_in_wait && !bus.mem_ready) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_timeout) r_timeout <= 1'b1;
      if (w_retire)      r_count   <= r_count + 1'b1;
    end
  end

  assign bus.state       = r_state;
  assign bus.illegal     = r_illegal;
  assign bus.timeout     = r_timeout;
  assign bus.instr_count = r_count;

endmodule
